seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Memory-mapped controller for the 8-digit 7-segment display on the CPU IO bus.
//  The CPU writes hex digit data, an enable mask and decimal points through IOWrite cycles.
//  The block owns the scan sequencing: prescaler, digit rotation, anti-ghost blanking and
//  tear-free frame update. It sits beside leds/switchs and is selected by MemOrIO.
// PARAMETERS
//  SCAN_DIV   23000  clk cycles per digit slot (~1 kHz slot rate at 23 MHz); must be >= 2
//  BLANK_CYC  64     cycles at start of each slot with all outputs off; must be < SCAN_DIV
// PORTS
//  clk        in   1   CPU clock (same as leds/switchs)
//  rst        in   1   asynchronous, active-high reset
//  segcs      in   1   chip select from MemOrIO
//  segwrite   in   1   IO write strobe (IOWrite)
//  segaddr    in   2   register select
//  segwdata   in   16  write data (write_data[15:0])
//  DIG        out  8   digit enables, active-low, one-hot-low when lit
//  Y          out  8   segments, active-low; Y[7]=dp, Y[6:0]=g..a
//  frame_done out  1   one-cycle pulse on each 7->0 digit wrap
// BEHAVIOUR
//  Register map (write when segcs&segwrite at posedge clk; no read path):
//   00: shadow data[15:0] (digits 3..0, 4 bits each)   01: shadow data[31:16] (digits 7..4)
//   10: shadow {dp[7:0], en[7:0]}                        11: bit0 = imm (1: bypass shadow)
//  Reset: shadow/active data=0, en=8'hFF, dp=0, imm=0, prescaler=0, digit=0,
//   DIG=8'hFF, Y=8'hFF, frame_done=0.
//  Prescaler counts 0..SCAN_DIV-1, wraps; tick when count==SCAN_DIV-1.
//  On tick digit <= digit+1 (mod 8). On tick with digit==7: active <= shadow (data,en,dp),
//   frame_done=1 next cycle for exactly one cycle.
//  Same-cycle write and 7->0 transfer: transfer copies pre-write shadow; new value shows
//   next frame. imm=1: writes go to shadow and active simultaneously; no transfer conflict.
//  Outputs registered (1-cycle latency from digit/count). During count<BLANK_CYC:
//   DIG=8'hFF, Y=8'hFF. Otherwise DIG=~(1<<digit) if en[digit] else 8'hFF;
//   Y={~dp[digit], ~hexseg(active nibble)} if en[digit] else 8'hFF.
//  Disabled digits still consume a full slot (uniform duty cycle).
//  hexseg: standard 0-F patterns (a=bit0 ... g=bit6, active-high before inversion).
//  Writes with segcs=0 or segwrite=0 ignored; writes during blank or mid-slot are legal.
//  rst mid-slot: all state returns to reset values immediately (async), outputs off.
// STRUCTURE
//  Shared package seg7_pkg: address constants SEG_ADDR_LO/HI/CTRL/MODE, 16-entry hex
//   segment table, DIG_OFF/Y_OFF constants.
//  One sub-module: seg7_hex_decode (4-bit nibble -> 7-bit active-high segments, combinational).
//  Remainder (regs, prescaler, digit counter, output regs) lives in seg7_scan_ctrl.
// TESTING (SCAN_DIV=8, BLANK_CYC=2)
//  Reset: assert rst -> DIG=8'hFF, Y=8'hFF, frame_done=0; after release first lit slot
//   is digit0 showing '0' (Y=8'hC0, DIG=8'hFE) from cycle 3 of slot.
//  Write 00:16'h3210, 01:16'h7654 -> no change until next 7->0 wrap; then digits 0..7
//   show 0..7 in order, one slot each, frame_done pulses once per 64 cycles.
//  Write 10:16'h01_0F (dp0, digits 0-3 enabled) -> after transfer digits 4-7 slots keep
//   DIG=8'hFF; digit0 Y[7]=0; frame period still 64 cycles.
//  Write 00 on exact cycle of 7->0 transfer -> old value displayed this frame, new next frame.
//  Write 11:1 then 00:16'hFFFF -> digit0 shows 'F' (Y=8'h8E) in its next slot without waiting for wrap.
//  Assert rst mid-slot of digit5 -> outputs off same cycle; after release scan restarts at digit0, data=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and hex segment table for the 7-segment scan controller
package seg7_pkg;

    // Register select values on segaddr
    localparam logic [1:0] SEG_ADDR_LO   = 2'b00;  // shadow data[15:0]  (digits 3..0)
    localparam logic [1:0] SEG_ADDR_HI   = 2'b01;  // shadow data[31:16] (digits 7..4)
    localparam logic [1:0] SEG_ADDR_CTRL = 2'b10;  // shadow {dp[7:0], en[7:0]}
    localparam logic [1:0] SEG_ADDR_MODE = 2'b11;  // bit0 = imm

    // All-off values for the active-low outputs
    localparam logic [7:0] DIG_OFF = 8'hFF;
    localparam logic [7:0] Y_OFF   = 8'hFF;

    // Active-high segment patterns, bit0 = a ... bit6 = g, indexed by hex value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high 7-segment pattern
// Ports:
//   i_nibble  in  4  hex value 0..F
//   o_seg     out 7  segments g..a, active-high
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - memory-mapped 8-digit 7-segment scan controller with shadowed frame update
// Ports:
//   clk         in   1   CPU clock
//   rst         in   1   asynchronous active-high reset
//   segcs       in   1   chip select
//   segwrite    in   1   IO write strobe
//   segaddr     in   2   register select
//   segwdata    in  16   write data
//   DIG         out  8   digit enables, active-low
//   Y           out  8   segments, active-low, Y[7]=dp
//   frame_done  out  1   one-cycle pulse after each 7->0 digit wrap
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 23000,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        segcs,
    input  logic        segwrite,
    input  logic [1:0]  segaddr,
    input  logic [15:0] segwdata,
    output logic [7:0]  DIG,
    output logic [7:0]  Y,
    output logic        frame_done
);

    localparam int             CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYC);

    logic [CW-1:0] r_count;
    logic [2:0]    r_digit;
    logic [31:0]   r_sh_data;
    logic [7:0]    r_sh_en;
    logic [7:0]    r_sh_dp;
    logic [31:0]   r_act_data;
    logic [7:0]    r_act_en;
    logic [7:0]    r_act_dp;
    logic          r_imm;

    logic          w_wr;
    logic          w_tick;
    logic          w_xfer;
    logic [31:0]   w_act_data_nxt;
    logic [7:0]    w_act_en_nxt;
    logic [7:0]    w_act_dp_nxt;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;

    assign w_wr   = segcs & segwrite;
    assign w_tick = (r_count == CNT_MAX);
    assign w_xfer = w_tick && (r_digit == 3'd7);

    // Next active frame: the wrap copies the pre-write shadow, then an
    // immediate-mode write overlays the written field so it is never lost
    // to a coincident transfer.
    always_comb begin
        w_act_data_nxt = w_xfer ? r_sh_data : r_act_data;
        w_act_en_nxt   = w_xfer ? r_sh_en   : r_act_en;
        w_act_dp_nxt   = w_xfer ? r_sh_dp   : r_act_dp;
        if (w_wr && r_imm) begin
            case (segaddr)
                SEG_ADDR_LO:   w_act_data_nxt[15:0]  = segwdata;
                SEG_ADDR_HI:   w_act_data_nxt[31:16] = segwdata;
                SEG_ADDR_CTRL: begin
                    w_act_en_nxt = segwdata[7:0];
                    w_act_dp_nxt = segwdata[15:8];
                end
                default: ;
            endcase
        end
    end

    assign w_nib = r_act_data[{r_digit, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

    // Register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_data <= '0;
            r_sh_en   <= 8'hFF;
            r_sh_dp   <= '0;
            r_imm     <= 1'b0;
        end else if (w_wr) begin
            case (segaddr)
                SEG_ADDR_LO:   r_sh_data[15:0]  <= segwdata;
                SEG_ADDR_HI:   r_sh_data[31:16] <= segwdata;
                SEG_ADDR_CTRL: begin
                    r_sh_en <= segwdata[7:0];
                    r_sh_dp <= segwdata[15:8];
                end
                default:       r_imm <= segwdata[0];
            endcase
        end
    end

    // Active frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_data <= '0;
            r_act_en   <= 8'hFF;
            r_act_dp   <= '0;
        end else begin
            r_act_data <= w_act_data_nxt;
            r_act_en   <= w_act_en_nxt;
            r_act_dp   <= w_act_dp_nxt;
        end
    end

    // Prescaler and digit rotation; disabled digits still take a full slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_digit    <= '0;
            frame_done <= 1'b0;
        end else begin
            r_count    <= w_tick ? '0 : r_count + 1'b1;
            if (w_tick) begin
                r_digit <= r_digit + 3'd1;
            end
            frame_done <= w_xfer;
        end
    end

    // Registered outputs, one cycle behind count/digit; blanking at the start
    // of every slot keeps the previous digit's segments from ghosting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DIG <= DIG_OFF;
            Y   <= Y_OFF;
        end else if (r_count < BLANK_LIM || !r_act_en[r_digit]) begin
            DIG <= DIG_OFF;
            Y   <= Y_OFF;
        end else begin
            DIG <= ~(8'd1 << r_digit);
            Y   <= {~r_act_dp[r_digit], ~w_seg};
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - randomized self-checking bench for seg7_scan_ctrl against a frame-level model
module tb_seg7_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk;
    logic        rst;
    logic        segcs;
    logic        segwrite;
    logic [1:0]  segaddr;
    logic [15:0] segwdata;
    logic [7:0]  DIG;
    logic [7:0]  Y;
    logic        frame_done;

    int n_checks;
    int n_errors;

    // Model state: cycles since reset release, shadow and displayed frames per digit
    int       n;
    bit [3:0] sh_nib [8];
    bit [3:0] act_nib[8];
    bit       sh_en  [8];
    bit       act_en [8];
    bit       sh_dp  [8];
    bit       act_dp [8];
    bit       imm;

    seg7_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .segcs      (segcs),
        .segwrite   (segwrite),
        .segaddr    (segaddr),
        .segwdata   (segwdata),
        .DIG        (DIG),
        .Y          (Y),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit [6:0] seg_of(input bit [3:0] v);
        case (v)
            4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;  default: return 7'b1110001;
        endcase
    endfunction

    task automatic model_reset();
        n   = 0;
        imm = 0;
        for (int i = 0; i < 8; i++) begin
            sh_nib[i] = 0; act_nib[i] = 0;
            sh_en[i]  = 1; act_en[i]  = 1;
            sh_dp[i]  = 0; act_dp[i]  = 0;
        end
    endtask

    // One clock: drive inputs, predict outputs from the pre-edge slot, update model, compare.
    task automatic tick(input bit cs, input bit wr, input logic [1:0] a, input logic [15:0] d);
        int       cnt;
        int       dig;
        bit [7:0] edig;
        bit [7:0] ey;
        bit       efd;
        segcs = cs; segwrite = wr; segaddr = a; segwdata = d;
        cnt = n % DIV;
        dig = (n / DIV) % 8;
        if (cnt < BLANK || !act_en[dig]) begin
            edig = 8'hFF; ey = 8'hFF;
        end else begin
            edig = ~(8'd1 << dig);
            ey   = {~act_dp[dig], ~seg_of(act_nib[dig])};
        end
        efd = (cnt == DIV - 1) && (dig == 7);
        if (efd) begin
            for (int i = 0; i < 8; i++) begin
                act_nib[i] = sh_nib[i]; act_en[i] = sh_en[i]; act_dp[i] = sh_dp[i];
            end
        end
        if (cs && wr) begin
            case (a)
                2'd0, 2'd1: for (int i = 0; i < 4; i++) begin
                    sh_nib[a * 4 + i] = d[4 * i +: 4];
                    if (imm) act_nib[a * 4 + i] = d[4 * i +: 4];
                end
                2'd2: for (int i = 0; i < 8; i++) begin
                    sh_en[i] = d[i]; sh_dp[i] = d[8 + i];
                    if (imm) begin act_en[i] = d[i]; act_dp[i] = d[8 + i]; end
                end
                default: imm = d[0];
            endcase
        end
        n++;
        @(posedge clk);
        @(negedge clk);
        segcs = 0; segwrite = 0;
        check("DIG", {24'd0, DIG}, {24'd0, edig});
        check("Y", {24'd0, Y}, {24'd0, ey});
        check("frame_done", {31'd0, frame_done}, {31'd0, efd});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(0, 0, 2'd0, 16'h0);
    endtask

    task automatic check_off(input string tag);
        check({tag, "_DIG"}, {24'd0, DIG}, 32'hFF);
        check({tag, "_Y"}, {24'd0, Y}, 32'hFF);
        check({tag, "_fd"}, {31'd0, frame_done}, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1; segcs = 0; segwrite = 0; segaddr = 0; segwdata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_off("reset");
        rst = 0;

        // Power-up frame: digit0 shows '0' from cycle 3 of its slot
        idle(70);

        // Shadowed data: visible only after the next wrap
        tick(1, 1, 2'd0, 16'h3210);
        tick(1, 1, 2'd1, 16'h7654);
        idle(140);

        // dp0, digits 0-3 enabled; a write with segcs low must be ignored
        tick(1, 1, 2'd2, 16'h010F);
        tick(0, 1, 2'd0, 16'hAAAA);
        tick(1, 0, 2'd1, 16'hBBBB);
        idle(140);

        // Write landing on the exact 7->0 transfer cycle
        while (!((n % DIV) == DIV - 1 && ((n / DIV) % 8) == 7)) tick(0, 0, 2'd0, 16'h0);
        tick(1, 1, 2'd0, 16'($urandom));
        idle(130);

        // Immediate mode
        tick(1, 1, 2'd3, 16'h0001);
        tick(1, 1, 2'd0, 16'hFFFF);
        idle(70);

        // Random register traffic, including writes on transfer cycles
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom), 16'($urandom));
        end

        // Async reset in the middle of digit5's lit window
        tick(1, 1, 2'd3, 16'h0001);
        tick(1, 1, 2'd2, 16'h00FF);
        tick(1, 1, 2'd1, 16'($urandom));
        while (!(((n / DIV) % 8) == 5 && (n % DIV) == 4)) tick(0, 0, 2'd0, 16'h0);
        check("pre_rst_DIG", {24'd0, DIG}, 32'hDF);
        #2 rst = 1;
        #1 check_off("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_off("rst_hold");
        rst = 0;
        model_reset();
        idle(80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
